// File: rtl/melody_sequencer_if.sv
// rtl/melody_sequencer_if.sv - control, score ROM and audio signals of melody_sequencer
interface melody_sequencer_if #(
    parameter int NOTE_W = 4,
    parameter int DUR_W  = 3,
    parameter int ADDR_W = 6,
    parameter int DIV_W  = 16
);
    logic                    tick;
    logic                    start;
    logic                    stop;
    logic                    loop_en;
    logic [ADDR_W-1:0]       score_addr;
    logic [NOTE_W+DUR_W:0]   score_data;
    logic [NOTE_W-1:0]       note_code;
    logic [DIV_W-1:0]        half_period;
    logic                    wave;
    logic                    busy;
    logic                    note_strobe;
    logic                    done;

    modport master (
        input  tick, start, stop, loop_en, score_data, half_period,
        output score_addr, note_code, wave, busy, note_strobe, done
    );

    modport slave (
        output tick, start, stop, loop_en, score_data, half_period,
        input  score_addr, note_code, wave, busy, note_strobe, done
    );
endinterface

// File: rtl/melody_sequencer.sv
// rtl/melody_sequencer.sv - score-driven tone player: fetches note records, times them on tempo ticks, emits a square wave
module melody_sequencer #(
    parameter int NOTE_W    = 4,
    parameter int DUR_W     = 3,
    parameter int ADDR_W    = 6,
    parameter int DIV_W     = 16,
    parameter int GAP_TICKS = 1
) (
    input  logic               clk,
    input  logic               nRST,
    melody_sequencer_if.master io_seq
);
    localparam int GAP_W = $clog2(GAP_TICKS + 2);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_PLAY, S_GAP} state_t;

    state_t             r_state, w_state_nxt, w_after_note;
    logic [ADDR_W-1:0]  r_addr, w_addr_nxt;
    logic [NOTE_W-1:0]  r_note, w_note_nxt;
    logic [DUR_W-1:0]   r_dur, w_dur_nxt;
    logic [DUR_W-1:0]   r_dur_cnt, w_dur_cnt_nxt;
    logic [GAP_W-1:0]   r_gap_cnt, w_gap_cnt_nxt;
    logic [DIV_W-1:0]   r_per_cnt, w_per_cnt_nxt;
    logic               r_wave, w_wave_nxt;
    logic               r_loop, w_loop_nxt;
    logic               r_strobe, w_strobe_nxt;
    logic               r_done, w_done_nxt;
    logic               r_busy;

    wire                w_end      = io_seq.score_data[NOTE_W+DUR_W];
    wire [DUR_W-1:0]    w_rec_dur  = io_seq.score_data[NOTE_W +: DUR_W];
    wire [NOTE_W-1:0]   w_rec_note = io_seq.score_data[NOTE_W-1:0];
    wire                w_last     = &r_addr;
    wire                w_note_over = io_seq.tick && (r_dur_cnt == r_dur);
    wire                w_gap_over  = io_seq.tick && (r_gap_cnt == GAP_LAST);
    wire                w_tone_on   = (r_note != '0) && (io_seq.half_period != '0);

    // Running off the top of the score is treated exactly like an end record.
    assign w_after_note = (w_last && !r_loop) ? S_IDLE : S_FETCH;

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (io_seq.stop) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (io_seq.start) w_state_nxt = S_FETCH;
                S_FETCH: w_state_nxt = S_LOAD;
                S_LOAD:  w_state_nxt = w_end ? (io_seq.loop_en ? S_FETCH : S_IDLE) : S_PLAY;
                S_PLAY:  if (w_note_over) w_state_nxt = (GAP_TICKS > 0) ? S_GAP : w_after_note;
                S_GAP:   if (w_gap_over) w_state_nxt = w_after_note;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_addr_nxt    = r_addr;
        w_note_nxt    = r_note;
        w_dur_nxt     = r_dur;
        w_dur_cnt_nxt = r_dur_cnt;
        w_gap_cnt_nxt = r_gap_cnt;
        w_per_cnt_nxt = r_per_cnt;
        w_wave_nxt    = r_wave;
        w_loop_nxt    = r_loop;
        w_strobe_nxt  = 1'b0;
        w_done_nxt    = 1'b0;
        if (io_seq.stop) begin
            w_note_nxt    = '0;
            w_wave_nxt    = 1'b0;
            w_per_cnt_nxt = '0;
        end else begin
            case (r_state)
                S_IDLE: if (io_seq.start) w_addr_nxt = '0;
                S_LOAD: begin
                    w_loop_nxt = io_seq.loop_en;
                    if (w_end) begin
                        if (io_seq.loop_en) w_addr_nxt = '0;
                        else                w_done_nxt = 1'b1;
                    end else begin
                        w_note_nxt    = w_rec_note;
                        w_dur_nxt     = w_rec_dur;
                        w_dur_cnt_nxt = '0;
                        w_per_cnt_nxt = '0;
                        w_wave_nxt    = 1'b0;
                        w_strobe_nxt  = 1'b1;
                    end
                end
                S_PLAY: begin
                    // >= rather than == so a shortened half period mid-note still wraps.
                    if (!w_tone_on) begin
                        w_wave_nxt    = 1'b0;
                        w_per_cnt_nxt = '0;
                    end else if (r_per_cnt >= io_seq.half_period - DIV_W'(1)) begin
                        w_wave_nxt    = ~r_wave;
                        w_per_cnt_nxt = '0;
                    end else begin
                        w_per_cnt_nxt = r_per_cnt + DIV_W'(1);
                    end
                    if (io_seq.tick) w_dur_cnt_nxt = r_dur_cnt + DUR_W'(1);
                    if (w_note_over) begin
                        w_note_nxt    = '0;
                        w_wave_nxt    = 1'b0;
                        w_per_cnt_nxt = '0;
                        w_gap_cnt_nxt = '0;
                        if (GAP_TICKS == 0) begin
                            if (!w_last)     w_addr_nxt = r_addr + ADDR_W'(1);
                            else if (r_loop) w_addr_nxt = '0;
                            else             w_done_nxt = 1'b1;
                        end
                    end
                end
                S_GAP: begin
                    if (io_seq.tick) w_gap_cnt_nxt = r_gap_cnt + GAP_W'(1);
                    if (w_gap_over) begin
                        if (!w_last)     w_addr_nxt = r_addr + ADDR_W'(1);
                        else if (r_loop) w_addr_nxt = '0;
                        else             w_done_nxt = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            r_addr    <= '0;
            r_note    <= '0;
            r_dur     <= '0;
            r_dur_cnt <= '0;
            r_gap_cnt <= '0;
            r_per_cnt <= '0;
            r_wave    <= 1'b0;
            r_loop    <= 1'b0;
            r_strobe  <= 1'b0;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_addr    <= w_addr_nxt;
            r_note    <= w_note_nxt;
            r_dur     <= w_dur_nxt;
            r_dur_cnt <= w_dur_cnt_nxt;
            r_gap_cnt <= w_gap_cnt_nxt;
            r_per_cnt <= w_per_cnt_nxt;
            r_wave    <= w_wave_nxt;
            r_loop    <= w_loop_nxt;
            r_strobe  <= w_strobe_nxt;
            r_done    <= w_done_nxt;
            r_busy    <= (w_state_nxt != S_IDLE);
        end
    end

    assign io_seq.score_addr  = r_addr;
    assign io_seq.note_code   = r_note;
    assign io_seq.wave        = r_wave;
    assign io_seq.busy        = r_busy;
    assign io_seq.note_strobe = r_strobe;
    assign io_seq.done        = r_done;
endmodule

// File: tb/tb_melody_sequencer.sv
// tb/tb_melody_sequencer.sv - bench for melody_sequencer against a note-timeline reference model
module tb_melody_sequencer;
    localparam int NOTE_W    = 4;
    localparam int DUR_W     = 3;
    localparam int ADDR_W    = 2;
    localparam int DIV_W     = 16;
    localparam int GAP_TICKS = 1;

    logic clk  = 1'b0;
    logic nRST = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [7:0] rom [4];

    melody_sequencer_if #(.NOTE_W(NOTE_W), .DUR_W(DUR_W), .ADDR_W(ADDR_W), .DIV_W(DIV_W)) bus ();

    melody_sequencer #(
        .NOTE_W(NOTE_W), .DUR_W(DUR_W), .ADDR_W(ADDR_W), .DIV_W(DIV_W), .GAP_TICKS(GAP_TICKS)
    ) dut (
        .clk(clk),
        .nRST(nRST),
        .io_seq(bus.master)
    );

    always #5 clk = ~clk;

    always @(posedge clk) bus.score_data <= rom[bus.score_addr];
    assign bus.half_period = DIV_W'(bus.note_code ^ 4'd1);

    function automatic int hp_of(input int c);
        return c ^ 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_score(input logic [7:0] r0, input logic [7:0] r1,
                              input logic [7:0] r2, input logic [7:0] r3);
        rom[0] = r0; rom[1] = r1; rom[2] = r2; rom[3] = r3;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_addr"},   32'(bus.score_addr),  32'd0);
        chk({tag, "_note"},   32'(bus.note_code),   32'd0);
        chk({tag, "_wave"},   32'(bus.wave),        32'd0);
        chk({tag, "_busy"},   32'(bus.busy),        32'd0);
        chk({tag, "_strobe"}, 32'(bus.note_strobe), 32'd0);
        chk({tag, "_done"},   32'(bus.done),        32'd0);
    endtask

    // mode 0: play until done (or until 3 loops, then stop); 1: stop while wave high; 2: async reset while wave high
    task automatic run_score(input bit lp, input int mode, input int max_cyc);
        int n, next_tick, evt_kind, evt_cyc, evt_addr, cur_addr, p, tcnt, gcnt, dur, zero_strobes, exp_wave, hp;
        bit st, sp, tk, act, in_note, in_gap, fin, rec_done, exp_strobe, exp_done;
        logic [3:0] code;
        @(negedge clk);
        bus.loop_en = lp; bus.start = 1'b1; bus.stop = 1'b0; bus.tick = 1'b0;
        st = 1; sp = 0; tk = 0;
        next_tick = 5 + $urandom_range(0, 4);
        act = 0; in_note = 0; in_gap = 0; fin = 0; evt_kind = 0; evt_cyc = 0; evt_addr = 0;
        cur_addr = 0; p = 0; tcnt = 0; gcnt = 0; dur = 0; code = '0; zero_strobes = 0;
        for (n = 0; !fin && n <= max_cyc; n++) begin
            @(negedge clk);
            exp_strobe = 0; exp_done = 0;
            if (sp) begin
                act = 0; in_note = 0; in_gap = 0; evt_kind = 0; fin = 1;
            end else begin
                if (st && !act) begin
                    act = 1; evt_kind = 1; evt_cyc = n + 2; evt_addr = 0;
                end
                rec_done = 0;
                if (in_note && tk) begin
                    tcnt++;
                    if (tcnt == dur + 1) begin
                        in_note = 0;
                        if (GAP_TICKS == 0) rec_done = 1;
                        else begin in_gap = 1; gcnt = 0; end
                    end
                end else if (in_gap && tk) begin
                    gcnt++;
                    if (gcnt == GAP_TICKS) begin in_gap = 0; rec_done = 1; end
                end
                if (rec_done) begin
                    if (cur_addr == 3) begin
                        if (lp) begin evt_kind = 1; evt_cyc = n + 2; evt_addr = 0; end
                        else    begin evt_kind = 2; evt_cyc = n; end
                    end else if (rom[cur_addr + 1][7]) begin
                        if (lp) begin evt_kind = 1; evt_cyc = n + 4; evt_addr = 0; end
                        else    begin evt_kind = 2; evt_cyc = n + 2; end
                    end else begin
                        evt_kind = 1; evt_cyc = n + 2; evt_addr = cur_addr + 1;
                    end
                end
                exp_strobe = (evt_kind == 1) && (evt_cyc == n);
                exp_done   = (evt_kind == 2) && (evt_cyc == n);
                if (exp_strobe) begin
                    in_note = 1; p = n; cur_addr = evt_addr; tcnt = 0; evt_kind = 0;
                    code = rom[cur_addr][3:0];
                    dur  = int'(rom[cur_addr][6:4]);
                    if (cur_addr == 0) zero_strobes++;
                end
                if (exp_done) begin act = 0; evt_kind = 0; fin = 1; end
            end
            exp_wave = 0;
            if (in_note) begin
                hp = hp_of(int'(code));
                if (code != 0 && hp != 0) exp_wave = ((n - p) / hp) % 2;
            end
            chk("note_strobe", 32'(bus.note_strobe), 32'(exp_strobe));
            chk("done",        32'(bus.done),        32'(exp_done));
            chk("busy",        32'(bus.busy),        32'(act));
            chk("note_code",   32'(bus.note_code),   in_note ? 32'(code) : 32'd0);
            chk("wave",        32'(bus.wave),        32'(exp_wave));
            if (exp_strobe) chk("score_addr", 32'(bus.score_addr), 32'(cur_addr));
            st = 0; sp = 0;
            if (lp && zero_strobes >= 4) sp = 1;
            if (mode == 1 && exp_wave == 1) sp = 1;
            tk = (n + 1 == next_tick);
            if (tk) next_tick += $urandom_range(5, 9);
            bus.start = st; bus.stop = sp; bus.tick = tk;
            if (mode == 2 && exp_wave == 1 && !fin) begin
                #2 nRST = 1'b0;
                #1 chk_quiet("async_reset");
                bus.tick = 1'b0; bus.stop = 1'b0;
                @(negedge clk);
                nRST = 1'b1;
                fin = 1;
            end
        end
        chk("run_finished", 32'(fin), 32'd1);
        bus.start = 1'b0; bus.stop = 1'b0; bus.tick = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        logic [7:0] rec;
        bus.tick = 1'b0; bus.start = 1'b0; bus.stop = 1'b0; bus.loop_en = 1'b0;
        load_score(8'h25, 8'h03, 8'h80, 8'h80);
        repeat (3) @(negedge clk);
        chk_quiet("reset");
        nRST = 1'b1;
        @(negedge clk);

        run_score(1'b0, 0, 2000);
        run_score(1'b1, 0, 4000);

        load_score(8'h10, 8'h80, 8'h80, 8'h80);
        run_score(1'b0, 0, 2000);

        load_score(8'h25, 8'h03, 8'h80, 8'h80);
        run_score(1'b0, 1, 2000);

        bus.start = 1'b1; bus.stop = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.stop = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("start_stop_busy",   32'(bus.busy),        32'd0);
            chk("start_stop_strobe", 32'(bus.note_strobe), 32'd0);
            @(negedge clk);
        end

        for (int a = 0; a < 4; a++) begin
            rec = 8'($urandom_range(0, 127));
            rom[a] = rec;
        end
        run_score(1'b0, 0, 3000);

        load_score(8'h25, 8'h03, 8'h80, 8'h80);
        run_score(1'b0, 2, 2000);
        run_score(1'b0, 0, 2000);

        for (int r = 0; r < 6; r++) begin
            for (int a = 0; a < 4; a++) begin
                rec = 8'($urandom_range(0, 127));
                if (a > 0 && $urandom_range(0, 3) == 0) rec[7] = 1'b1;
                rom[a] = rec;
            end
            run_score(1'($urandom_range(0, 1)), 0, 5000);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
